// File: rtl/digest_streamer_pkg.sv
// digest_streamer_pkg
// Shared types and constants for the digest streamer:
//   state_t          - sequencing FSM states
//   UART_START_BIT   - line level of a UART start bit
//   UART_STOP_BIT    - line level of a UART stop bit (also the idle level)
//   ASCII_CR/LF      - line terminator sent after a hex-encoded digest
//   nibble_to_ascii  - 4-bit value to lowercase ASCII hex character
package digest_streamer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_GAP,
      ST_FIN
   } state_t;

   localparam logic       UART_START_BIT = 1'b0;
   localparam logic       UART_STOP_BIT  = 1'b1;
   localparam logic [7:0] ASCII_CR       = 8'h0D;
   localparam logic [7:0] ASCII_LF       = 8'h0A;

   // 0-9 -> '0'-'9', 10-15 -> 'a'-'f' ('a' - 10 = 0x57)
   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
      if (nib < 4'd10) begin
         return 8'h30 + {4'h0, nib};
      end
      return 8'h57 + {4'h0, nib};
   endfunction

endpackage

// File: rtl/digest_streamer_uart_tx_core.sv
// uart_tx_core
// Single-frame UART transmitter: one start bit, 8 data bits LSB first,
// one stop bit, each CLKS_PER_BIT clocks long.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset (line forced high)
//   start       - begin a frame with data_byte; ignored while a frame is active
//   data_byte   - byte to send, sampled when start is accepted
//   line        - serial output, idle high
//   frame_done  - high during the last clock of the stop bit
module uart_tx_core
   import digest_streamer_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data_byte,
   output logic       line,
   output logic       frame_done
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

   logic [TW-1:0] timer_reg;
   logic [3:0]    bit_idx_reg;   // 0 = start, 1..8 = data, 9 = stop
   logic [7:0]    shift_reg;
   logic          active_reg;
   logic          line_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_reg   <= '0;
         bit_idx_reg <= '0;
         shift_reg   <= '0;
         active_reg  <= 1'b0;
         line_reg    <= UART_STOP_BIT;
      end else if (!active_reg) begin
         if (start) begin
            active_reg  <= 1'b1;
            line_reg    <= UART_START_BIT;
            shift_reg   <= data_byte;
            timer_reg   <= '0;
            bit_idx_reg <= '0;
         end
      end else if (timer_reg == LAST_TICK) begin
         timer_reg <= '0;
         if (bit_idx_reg == 4'd9) begin
            active_reg <= 1'b0;
         end else begin
            bit_idx_reg <= bit_idx_reg + 4'd1;
            if (bit_idx_reg == 4'd8) begin
               line_reg <= UART_STOP_BIT;
            end else begin
               line_reg  <= shift_reg[0];
               shift_reg <= {1'b0, shift_reg[7:1]};
            end
         end
      end else begin
         timer_reg <= timer_reg + 1'b1;
      end
   end

   assign line       = line_reg;
   assign frame_done = active_reg && (bit_idx_reg == 4'd9) && (timer_reg == LAST_TICK);

endmodule

// File: rtl/digest_streamer.sv
// digest_streamer
// Accepts a digest through a valid/ready handshake and sends it out as a
// sequence of UART frames, with two idle-high clocks between frames.
// Build option: define DIGEST_STREAMER_HEX_EN to send each byte as two
// lowercase ASCII hex characters (high nibble first) followed by CR LF.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   digest        - digest to send, captured at the handshake only
//   digest_valid  - digest offered
//   digest_ready  - high only while idle
//   uart_tx       - serial line, idle high
//   busy          - handshake through the done pulse
//   done          - one-cycle pulse after the final stop bit
module digest_streamer
   import digest_streamer_pkg::*;
#(
   parameter int DIGEST_W     = 256,
   parameter int CLKS_PER_BIT = 87,
   parameter int MSB_FIRST    = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DIGEST_W-1:0] digest,
   input  logic                digest_valid,
   output logic                digest_ready,
   output logic                uart_tx,
   output logic                busy,
   output logic                done
);

   if (DIGEST_W < 8 || (DIGEST_W % 8) != 0) begin : g_bad_digest_w
      $error("digest_streamer: DIGEST_W must be a positive multiple of 8");
   end
   if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("digest_streamer: CLKS_PER_BIT must be at least 2");
   end

   localparam int NBYTES = DIGEST_W / 8;
`ifdef DIGEST_STREAMER_HEX_EN
   localparam int FRAMES = DIGEST_W / 4 + 2;
`else
   localparam int FRAMES = NBYTES;
`endif
   localparam int IDX_W = $clog2(FRAMES + 1);
   localparam int TW    = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

   state_t              state_reg;
   logic [IDX_W-1:0]    byte_idx_reg;
   logic [TW-1:0]       timer_reg;
   logic [2:0]          bit_cnt_reg;
   logic [DIGEST_W-1:0] shadow_reg;
   logic [7:0]          tx_byte_reg;
   logic                start_reg;
   logic                ready_reg;
   logic                busy_reg;
   logic                done_reg;
   logic                frame_done;

   logic [7:0]          cur_byte;
   logic [7:0]          next_byte;
   int                  byte_sel;

   // Frame index -> digest byte -> transmitted character
   always_comb begin
      byte_sel = int'(byte_idx_reg);
`ifdef DIGEST_STREAMER_HEX_EN
      byte_sel = byte_sel / 2;
`endif
      // CR/LF frames point past the digest; keep the select in range
      if (byte_sel >= NBYTES) byte_sel = 0;
      if (MSB_FIRST != 0) byte_sel = NBYTES - 1 - byte_sel;
      cur_byte = shadow_reg[8*byte_sel +: 8];
`ifdef DIGEST_STREAMER_HEX_EN
      if (byte_idx_reg < IDX_W'(2 * NBYTES)) begin
         next_byte = nibble_to_ascii(byte_idx_reg[0] ? cur_byte[3:0] : cur_byte[7:4]);
      end else if (byte_idx_reg == IDX_W'(2 * NBYTES)) begin
         next_byte = ASCII_CR;
      end else begin
         next_byte = ASCII_LF;
      end
`else
      next_byte = cur_byte;
`endif
   end

   // The FSM runs one clock ahead of the line: start_reg is raised on the
   // LOAD->START edge and the core drives the start bit one edge later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         byte_idx_reg <= '0;
         timer_reg    <= '0;
         bit_cnt_reg  <= '0;
         shadow_reg   <= '0;
         tx_byte_reg  <= '0;
         start_reg    <= 1'b0;
         ready_reg    <= 1'b1;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         start_reg <= 1'b0;
         done_reg  <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (digest_valid && ready_reg) begin
                  shadow_reg   <= digest;
                  byte_idx_reg <= '0;
                  ready_reg    <= 1'b0;
                  busy_reg     <= 1'b1;
                  state_reg    <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               tx_byte_reg <= next_byte;
               start_reg   <= 1'b1;
               timer_reg   <= '0;
               state_reg   <= ST_START;
            end
            ST_START: begin
               if (timer_reg == LAST_TICK) begin
                  timer_reg   <= '0;
                  bit_cnt_reg <= '0;
                  state_reg   <= ST_DATA;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end
            ST_DATA: begin
               if (timer_reg == LAST_TICK) begin
                  timer_reg <= '0;
                  if (bit_cnt_reg == 3'd7) begin
                     state_reg <= ST_STOP;
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + 3'd1;
                  end
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end
            ST_STOP: begin
               if (timer_reg == LAST_TICK) begin
                  timer_reg <= '0;
                  state_reg <= ST_GAP;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end
            ST_GAP: begin
               // Lines up with the core's final stop-bit clock
               if (frame_done) begin
                  byte_idx_reg <= byte_idx_reg + 1'b1;
                  if (byte_idx_reg == IDX_W'(FRAMES - 1)) begin
                     done_reg  <= 1'b1;
                     state_reg <= ST_FIN;
                  end else begin
                     state_reg <= ST_LOAD;
                  end
               end
            end
            ST_FIN: begin
               ready_reg <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   uart_tx_core #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_core (
      .clk        (clk),
      .rst        (rst),
      .start      (start_reg),
      .data_byte  (tx_byte_reg),
      .line       (uart_tx),
      .frame_done (frame_done)
   );

   assign digest_ready = ready_reg;
   assign busy         = busy_reg;
   assign done         = done_reg;

endmodule

// File: tb/tb_digest_streamer.sv
module tb_digest_streamer;

   localparam int CPB = 4;
`ifdef DIGEST_STREAMER_HEX_EN
   localparam int HEX    = 1;
   localparam int FRAMES = 66;
`else
   localparam int HEX    = 0;
   localparam int FRAMES = 32;
`endif
   localparam int XFER_CYC = FRAMES * 40 + (FRAMES - 1) * 2 + 2;
   localparam int RXN = 1024;

   logic         clk;
   logic         rst;
   logic [255:0] digest;
   logic         digest_valid;
   logic [1:0]   ready;
   logic [1:0]   tx;
   logic [1:0]   busy;
   logic [1:0]   done;

   int checks   = 0;
   int failures = 0;

   digest_streamer #(.DIGEST_W(256), .CLKS_PER_BIT(CPB), .MSB_FIRST(1)) u_msb (
      .clk(clk), .rst(rst), .digest(digest), .digest_valid(digest_valid),
      .digest_ready(ready[0]), .uart_tx(tx[0]), .busy(busy[0]), .done(done[0]));

   digest_streamer #(.DIGEST_W(256), .CLKS_PER_BIT(CPB), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .rst(rst), .digest(digest), .digest_valid(digest_valid),
      .digest_ready(ready[1]), .uart_tx(tx[1]), .busy(busy[1]), .done(done[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // UART receivers, one per DUT, sampling mid-bit on falling edges
   logic [7:0] rx_byte [2][RXN];
   longint     rx_t    [2][RXN];
   int         rx_cnt  [2] = '{0, 0};
   int         dec_cnt [2] = '{0, 0};
   logic       dec_act [2] = '{1'b0, 1'b0};
   logic [7:0] dec_sh  [2];
   int         frame_err [2] = '{0, 0};
   int         state_err [2] = '{0, 0};

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            dec_act[i] <= 1'b0;
         end else if (!dec_act[i]) begin
            if (tx[i] == 1'b0) begin
               dec_act[i] <= 1'b1;
               dec_cnt[i] <= 1;
               if (rx_cnt[i] < RXN) rx_t[i][rx_cnt[i]] <= longint'($time);
            end
         end else begin
            dec_cnt[i] <= dec_cnt[i] + 1;
            if (dec_cnt[i] >= CPB + 1 && dec_cnt[i] <= 8 * CPB + 1 && (dec_cnt[i] - 1) % CPB == 0)
               dec_sh[i] <= {tx[i], dec_sh[i][7:1]};
            if (dec_cnt[i] == 9 * CPB + 1) begin
               if (tx[i] !== 1'b1) frame_err[i] <= frame_err[i] + 1;
               if (rx_cnt[i] < RXN) rx_byte[i][rx_cnt[i]] <= dec_sh[i];
               rx_cnt[i]  <= rx_cnt[i] + 1;
               dec_act[i] <= 1'b0;
            end
         end
         // ready is high exactly when the block is not busy
         if (!rst && ready[i] === busy[i]) state_err[i] <= state_err[i] + 1;
      end
   end

   // Handshake and done monitors
   int     hs_cnt = 0;
   longint hs_t   = 0;
   int     done_cnt [2] = '{0, 0};
   longint done_t   [2] = '{0, 0};

   always @(posedge clk) begin
      if (!rst && digest_valid && ready[0]) begin
         hs_cnt <= hs_cnt + 1;
         hs_t   <= longint'($time);
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (done[i]) begin
            done_cnt[i] <= done_cnt[i] + 1;
            done_t[i]   <= longint'($time) - 5;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Expected character of frame f for a given digest and byte order
   function automatic logic [7:0] exp_frame(input logic [255:0] d, input int msb, input int f);
      int b;
      logic [7:0] v;
      logic [3:0] n;
      if (HEX != 0 && f == 64) return 8'h0D;
      if (HEX != 0 && f == 65) return 8'h0A;
      b = (HEX != 0) ? f / 2 : f;
      if (msb != 0) b = 31 - b;
      v = d[8*b +: 8];
      if (HEX == 0) return v;
      n = (f % 2 == 1) ? v[3:0] : v[7:4];
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
   endfunction

   task automatic wait_hs(input int target, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (hs_cnt >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_done(input int target, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < XFER_CYC + 200; n++) begin
         @(negedge clk);
         if (done_cnt[0] >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Stream contents, frame spacing and first start-bit latency for one transfer
   task automatic verify_xfer(input string name, input int b0, input int b1,
                              input logic [255:0] d, input longint t_h);
      int base;
      int bad;
      int gaps;
      for (int i = 0; i < 2; i++) begin
         base = (i == 0) ? b0 : b1;
         bad  = 0;
         gaps = 0;
         for (int f = 0; f < FRAMES; f++) begin
            if (rx_byte[i][base+f] !== exp_frame(d, (i == 0) ? 1 : 0, f)) bad++;
            if (f > 0 && rx_t[i][base+f] - rx_t[i][base+f-1] != 420) gaps++;
         end
         chk($sformatf("%s_data_dut%0d", name, i), bad, 0);
         chk($sformatf("%s_spacing_dut%0d", name, i), gaps, 0);
         chk($sformatf("%s_first_start_dut%0d", name, i), rx_t[i][base] - t_h, 25);
         $display("xfer %s dut%0d: first=%02h last=%02h bad_frames=%0d",
                  name, i, rx_byte[i][base], rx_byte[i][base+FRAMES-1], bad);
      end
   endtask

   typedef struct {
      string      name;
      int         dut;
      int         frame;
      logic [7:0] exp;
   } vec_t;

   initial begin
      vec_t         tbl [8];
      logic [255:0] dig_a;
      logic [255:0] dig_b;
      int           b0;
      int           b1;
      int           dc;
      bit           ok;
      longint       t_hs;
      longint       t_done;

      dig_a = 256'hb94d27b9934d3e08a52e52d7da7dabfac484efe37a5380ee9088f7ace2efcde9;
      dig_b = 256'h5a0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1ec3;
`ifdef DIGEST_STREAMER_HEX_EN
      tbl[0] = '{"msb_f0", 0, 0, 8'h62};
      tbl[1] = '{"msb_f1", 0, 1, 8'h39};
      tbl[2] = '{"msb_f2", 0, 2, 8'h34};
      tbl[3] = '{"msb_f3", 0, 3, 8'h64};
      tbl[4] = '{"msb_f63", 0, 63, 8'h39};
      tbl[5] = '{"msb_f64", 0, 64, 8'h0D};
      tbl[6] = '{"msb_f65", 0, 65, 8'h0A};
      tbl[7] = '{"lsb_f0", 1, 0, 8'h65};
`else
      tbl[0] = '{"msb_f0", 0, 0, 8'hB9};
      tbl[1] = '{"msb_f1", 0, 1, 8'h4D};
      tbl[2] = '{"msb_f30", 0, 30, 8'hCD};
      tbl[3] = '{"msb_f31", 0, 31, 8'hE9};
      tbl[4] = '{"lsb_f0", 1, 0, 8'hE9};
      tbl[5] = '{"lsb_f1", 1, 1, 8'hCD};
      tbl[6] = '{"lsb_f30", 1, 30, 8'h4D};
      tbl[7] = '{"lsb_f31", 1, 31, 8'hB9};
`endif

      // Reset state, and release of reset alone starts nothing
      rst = 1'b1;
      digest_valid = 1'b0;
      digest = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", ready, 2'b11);
      chk("rst_tx", tx, 2'b11);
      chk("rst_busy", busy, 2'b00);
      chk("rst_done", done, 2'b00);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("release_ready", ready, 2'b11);
      chk("release_busy", busy, 2'b00);
      chk("release_no_hs", hs_cnt, 0);
      chk("release_tx", tx, 2'b11);

      // Transfer 1: hello-world digest, input scrambled after capture
      b0 = rx_cnt[0];
      b1 = rx_cnt[1];
      digest = dig_a;
      digest_valid = 1'b1;
      wait_hs(1, ok);
      chk("xfer1_hs_seen", ok, 1);
      t_hs = hs_t;
      digest_valid = 1'b0;
      digest = ~dig_a;
      wait_done(1, ok);
      chk("xfer1_done_seen", ok, 1);
      t_done = done_t[0];
      repeat (6) @(negedge clk);
      chk("xfer1_latency", (t_done - t_hs) / 10, XFER_CYC);
      chk("xfer1_done_once_dut0", done_cnt[0], 1);
      chk("xfer1_done_once_dut1", done_cnt[1], 1);
      chk("xfer1_frames_dut0", rx_cnt[0] - b0, FRAMES);
      chk("xfer1_frames_dut1", rx_cnt[1] - b1, FRAMES);
      chk("xfer1_ready_after", ready, 2'b11);
      for (int k = 0; k < 8; k++)
         chk(tbl[k].name, rx_byte[tbl[k].dut][((tbl[k].dut == 0) ? b0 : b1) + tbl[k].frame], tbl[k].exp);
      verify_xfer("xfer1", b0, b1, dig_a, t_hs);

      // Reset during the data bits of frame 5
      b0 = rx_cnt[0];
      b1 = rx_cnt[1];
      dc = done_cnt[0];
      digest = dig_a;
      digest_valid = 1'b1;
      wait_hs(2, ok);
      chk("abort_hs_seen", ok, 1);
      digest_valid = 1'b0;
      ok = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (rx_cnt[0] >= b0 + 4 && dec_act[0]) begin
            ok = 1'b1;
            break;
         end
      end
      chk("abort_frame5_seen", ok, 1);
      repeat (12) @(negedge clk);
      #2;
      chk("abort_mid_bit_low", tx[0], 1'b0);
      rst = 1'b1;
      #1;
      chk("abort_tx_async", tx, 2'b11);
      chk("abort_ready", ready, 2'b11);
      chk("abort_busy", busy, 2'b00);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("abort_no_done", done_cnt[0], dc);
      chk("abort_partial_frames", rx_cnt[0] - b0, 4);
      chk("abort_idle_tx", tx, 2'b11);
      chk("abort_idle_ready", ready, 2'b11);
      $display("xfer abort: frames before reset=%0d", rx_cnt[0] - b0);

      // Restart after abort begins again at frame 0
      b0 = rx_cnt[0];
      b1 = rx_cnt[1];
      digest_valid = 1'b1;
      wait_hs(3, ok);
      chk("restart_hs_seen", ok, 1);
      t_hs = hs_t;
      digest_valid = 1'b0;
      wait_done(dc + 1, ok);
      chk("restart_done_seen", ok, 1);
      repeat (6) @(negedge clk);
      chk("restart_first", rx_byte[0][b0], tbl[0].exp);
      chk("restart_frames", rx_cnt[0] - b0, FRAMES);
      verify_xfer("restart", b0, b1, dig_a, t_hs);

      // Back-to-back with digest_valid held high
      b0 = rx_cnt[0];
      b1 = rx_cnt[1];
      dc = done_cnt[0];
      digest = dig_a;
      digest_valid = 1'b1;
      wait_hs(4, ok);
      chk("b2b_hs1_seen", ok, 1);
      t_hs = hs_t;
      digest = dig_b;
      wait_done(dc + 1, ok);
      chk("b2b_done1_seen", ok, 1);
      t_done = done_t[0];
      wait_hs(5, ok);
      chk("b2b_hs2_seen", ok, 1);
      chk("b2b_hs2_after_done", (hs_t - t_done) / 10, 2);
      digest_valid = 1'b0;
      digest = ~dig_b;
      verify_xfer("b2b_a", b0, b1, dig_a, t_hs);
      t_hs = hs_t;
      wait_done(dc + 2, ok);
      chk("b2b_done2_seen", ok, 1);
      repeat (6) @(negedge clk);
      chk("b2b_frames_dut0", rx_cnt[0] - b0, 2 * FRAMES);
      chk("b2b_frames_dut1", rx_cnt[1] - b1, 2 * FRAMES);
      verify_xfer("b2b_b", b0 + FRAMES, b1 + FRAMES, dig_b, t_hs);

      chk("frame_err_dut0", frame_err[0], 0);
      chk("frame_err_dut1", frame_err[1], 0);
      chk("ready_busy_dut0", state_err[0], 0);
      chk("ready_busy_dut1", state_err[1], 0);
      chk("done_total_dut1", done_cnt[1], done_cnt[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/digest_streamer.md
DIGEST_STREAMER -- requirements
Module: digest_streamer

Interface
REQ-001 Parameter DIGEST_W, default 256: digest width in bits; SHALL be a multiple of 8, minimum 8.
REQ-002 Parameter CLKS_PER_BIT, default 87: clk cycles per UART bit; SHALL be at least 2.
REQ-003 Parameter MSB_FIRST, default 1: byte order; 1 = digest[DIGEST_W-1 -: 8] sent first, 0 = digest[7:0] sent first.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 digest  input  DIGEST_W  digest to transmit; sampled only at handshake.
REQ-007 digest_valid  input  1  digest offered.
REQ-008 digest_ready  output  1  block can accept a digest.
REQ-009 uart_tx  output  1  UART serial line, idle high.
REQ-010 busy  output  1  high from handshake until the done pulse, inclusive.
REQ-011 done  output  1  one-cycle pulse after the final stop bit.

Function
REQ-012 Handshake SHALL occur on a rising edge with digest_valid && digest_ready; digest SHALL be captured into an internal shadow register on that edge.
REQ-013 digest_ready SHALL be high only in IDLE; digest_valid while not ready SHALL be ignored, with no queuing.
REQ-014 FSM states SHALL be IDLE, LOAD, START, DATA, STOP, GAP, FIN.
REQ-015 FSM transitions SHALL be:
- IDLE->LOAD on handshake;
- LOAD->START;
- START->DATA after CLKS_PER_BIT cycles;
- DATA->STOP after 8 bits;
- STOP->GAP after CLKS_PER_BIT cycles;
- GAP->LOAD if frames remain, else GAP->FIN;
- FIN->IDLE.
REQ-016 Each UART frame SHALL be one start bit (0), 8 data bits LSB first and one stop bit (1), each exactly CLKS_PER_BIT cycles.
REQ-017 The first start bit SHALL drive uart_tx low on the second rising edge after the handshake edge.
REQ-018 Consecutive frames SHALL be separated by exactly 2 clk cycles of uart_tx high (GAP then LOAD).
REQ-019 The frame count SHALL be DIGEST_W/8 in raw mode.
REQ-020 The byte index counter SHALL be $clog2(frames+1) bits wide and SHALL NOT wrap within a transfer.
REQ-021 done SHALL assert in FIN for exactly one cycle; digest_ready SHALL rise on the following cycle.
REQ-022 A handshake is accepted in the cycle after FIN, giving back-to-back digests with one idle cycle between them.
REQ-023 A changing digest input during a transfer SHALL NOT affect transmitted data.

Reset
REQ-024 Reset values SHALL be: uart_tx=1, digest_ready=1, busy=0, done=0, FSM=IDLE, counters=0, shadow register=0.
REQ-025 Reset asserted mid-frame SHALL abort immediately, with uart_tx high asynchronously; no partial frame resumes after release.
REQ-026 Release of reset SHALL NOT by itself start a transfer.

Configuration
REQ-027 Macro DIGEST_STREAMER_HEX_EN defined: each digest byte SHALL be sent as two lowercase ASCII hex characters, high nibble first, followed by 0x0D 0x0A; frame count is DIGEST_W/4+2.
REQ-028 DIGEST_STREAMER_HEX_EN undefined: raw bytes only, DIGEST_W/8 frames; no hex logic is synthesised.

Structure
REQ-029 Package digest_streamer_pkg SHALL hold:
- the FSM state enum;
- UART start and stop bit constants;
- CR/LF constants;
- the nibble-to-ASCII function.
REQ-030 Sub-module uart_tx_core (bit timer plus shift register; inputs start and byte, outputs line and frame_done) SHALL implement REQ-016, instantiated once; the FSM in digest_streamer sequences bytes.
REQ-031 Illegal DIGEST_W or CLKS_PER_BIT SHALL cause an elaboration-time error.

Verification
All scenarios use CLKS_PER_BIT=4.
REQ-032 Raw, MSB_FIRST=1, digest = b94d27b9...2efcde9 (SHA-256 of "hello world") -> 32 frames, first 0xB9, last 0xE9, done once, 32*40+31*2+2 cycles handshake-to-done.
REQ-033 Raw, MSB_FIRST=0, same digest -> first frame 0xE9, last frame 0xB9.
REQ-034 HEX_EN, same digest -> 66 frames, starting 0x62 0x39 0x34 0x64 and ending 0x39 0x0D 0x0A.
REQ-035 Reset pulsed during the data bits of frame 5 -> uart_tx high in the same cycle, digest_ready=1, no done; a new handshake restarts from byte 0.
REQ-036 digest_valid held high continuously with two distinct digests -> second accepted exactly 1 cycle after done; its frames contain the second digest only, and inputs changed mid-transfer are not transmitted.
